// File: rtl/bsg_cache_non_blocking_req_arb.sv
// Shares one bsg_cache_non_blocking between num_req_p requesters.
// Requests are arbitrated round-robin, and the winner's index is stamped into
// the top lg_req_lp bits of the cache id. Responses are steered back to their
// source by those bits. Per-requester credit counters bound the number of
// outstanding responses, so one requester cannot fill the miss FIFO. A
// BLOCK_LD is charged block_size_in_words_p credits.
//
// Packet layout (MSB..LSB): opcode[6] | id | addr | data | mask[data/8].
// The opcode encodings for LD and BLOCK_LD are 6'b000011 and 6'b000111.
module bsg_cache_non_blocking_req_arb #(
  parameter int num_req_p             = 4,
  parameter int id_width_p            = 30,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int max_out_p             = 16,
  localparam int lg_req_lp       = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cnt_width_lp    = (max_out_p + 1 > 1) ? $clog2(max_out_p + 1) : 1,
  localparam int opcode_width_lp = 6,
  localparam int mask_width_lp   = data_width_p / 8,
  localparam int pkt_width_lp    = opcode_width_lp + id_width_p + addr_width_p
                                   + data_width_p + mask_width_lp
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,

  input  logic [num_req_p*pkt_width_lp-1:0]    req_pkt_i,
  input  logic [num_req_p-1:0]                 req_v_i,
  output logic [num_req_p-1:0]                 req_ready_o,

  output logic [pkt_width_lp-1:0]              cache_pkt_o,
  output logic                                 cache_v_o,
  input  logic                                 cache_ready_i,

  input  logic [data_width_p-1:0]              cache_data_i,
  input  logic [id_width_p-1:0]                cache_id_i,
  input  logic                                 cache_v_i,
  output logic                                 cache_yumi_o,

  output logic [data_width_p-1:0]              resp_data_o,
  output logic [id_width_p-lg_req_lp-1:0]      resp_id_o,
  output logic [num_req_p-1:0]                 resp_v_o,
  input  logic [num_req_p-1:0]                 resp_yumi_i,

  output logic [num_req_p*cnt_width_lp-1:0]    out_cnt_o
);

  localparam int id_lsb_lp  = addr_width_p + data_width_p + mask_width_lp;
  localparam int id_msb_lp  = id_lsb_lp + id_width_p - 1;
  localparam int op_lsb_lp  = id_lsb_lp + id_width_p;
  localparam int sum_w_lp   = cnt_width_lp + 1;

  localparam logic [opcode_width_lp-1:0] block_ld_op_lp = 6'b000111;
  localparam logic [sum_w_lp-1:0] max_out_lp    = sum_w_lp'(max_out_p);
  localparam logic [sum_w_lp-1:0] block_cost_lp = sum_w_lp'(block_size_in_words_p);
  localparam logic [lg_req_lp-1:0] last_idx_lp  = lg_req_lp'(num_req_p - 1);

  logic [lg_req_lp-1:0]    rr_ptr_r;
  logic [lg_req_lp-1:0]    rr_ptr_n;
  logic [cnt_width_lp-1:0] cnt_r [num_req_p];
  logic [cnt_width_lp-1:0] cnt_n [num_req_p];

  logic [pkt_width_lp-1:0] pkt  [num_req_p];
  logic [sum_w_lp-1:0]     cost [num_req_p];
  logic [num_req_p-1:0]    eligible;
  logic [lg_req_lp-1:0]    grant;
  logic                    grant_found;
  logic                    accept;

  logic [lg_req_lp-1:0]    src;
  logic                    src_ok;

  // Unpack requests, price each one, and decide which fit within their credits.
  always_comb begin
    for (int unsigned i = 0; i < num_req_p; i++) begin
      pkt[i]      = req_pkt_i[i*pkt_width_lp +: pkt_width_lp];
      cost[i]     = (pkt[i][op_lsb_lp +: opcode_width_lp] == block_ld_op_lp)
                    ? block_cost_lp : sum_w_lp'(1);
      // Sum is one bit wider than the counter so it cannot wrap.
      eligible[i] = req_v_i[i] & ((sum_w_lp'(cnt_r[i]) + cost[i]) <= max_out_lp);
    end
  end

  // Round-robin pick: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      int idx;
      idx = int'(rr_ptr_r) + int'(k);
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant       = lg_req_lp'(idx);
      end
    end
  end

  assign cache_v_o = |eligible;
  assign accept    = cache_v_o & cache_ready_i;
  assign rr_ptr_n  = (grant == last_idx_lp) ? '0 : grant + 1'b1;

  // Forward the granted packet with its source index stamped into the id.
  always_comb begin
    cache_pkt_o = pkt[grant];
    cache_pkt_o[id_msb_lp -: lg_req_lp] = grant;
    req_ready_o = '0;
    if (accept) req_ready_o[grant] = 1'b1;
  end

  assign src          = cache_id_i[id_width_p-1 -: lg_req_lp];
  assign src_ok       = (int'(src) < num_req_p);
  assign cache_yumi_o = cache_v_i & src_ok & resp_yumi_i[src];
  assign resp_data_o  = cache_data_i;
  assign resp_id_o    = cache_id_i[id_width_p-lg_req_lp-1:0];

  // Steer the response valid to its source only.
  always_comb begin
    resp_v_o = '0;
    if (cache_v_i && src_ok) resp_v_o[src] = 1'b1;
  end

  // Credit update: charge on accept, refund on consumed response; both may apply at once.
  always_comb begin
    for (int unsigned i = 0; i < num_req_p; i++) begin
      cnt_n[i] = cnt_r[i];
      if (accept && (grant == lg_req_lp'(i)))
        cnt_n[i] = cnt_n[i] + cost[i][cnt_width_lp-1:0];
      if (cache_yumi_o && (src == lg_req_lp'(i)))
        cnt_n[i] = cnt_n[i] - 1'b1;
      out_cnt_o[i*cnt_width_lp +: cnt_width_lp] = cnt_r[i];
    end
  end

  // State registers: round-robin pointer and credit counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_r <= '0;
      for (int unsigned i = 0; i < num_req_p; i++) cnt_r[i] <= '0;
    end else begin
      if (accept) rr_ptr_r <= rr_ptr_n;
      for (int unsigned i = 0; i < num_req_p; i++) cnt_r[i] <= cnt_n[i];
    end
  end

`ifndef SYNTHESIS
  // Protocol checks; silent in reset because in-flight responses are then undefined.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (cache_v_i) begin
        assert (src_ok)
          else $error("response source %0d out of range", src);
        if (src_ok)
          assert (cnt_r[src] != '0)
            else $error("response for source %0d with no outstanding credit", src);
      end
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (req_v_i[i])
          assert (pkt[i][id_msb_lp -: lg_req_lp] == '0)
            else $error("requester %0d drives reserved id bits", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_cache_non_blocking_req_arb.sv
module tb_bsg_cache_non_blocking_req_arb;

  localparam int N  = 4;
  localparam int CW = 5;
  localparam int PW = 104;
  localparam logic [5:0] OP_LD  = 6'b000011;
  localparam logic [5:0] OP_BLK = 6'b000111;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [PW-1:0]   pkt [N];
  logic [N*PW-1:0] req_pkt_i;
  logic [N-1:0]    req_v_i;
  logic [N-1:0]    req_ready_o;
  logic [PW-1:0]   cache_pkt_o;
  logic            cache_v_o;
  logic            cache_ready_i;
  logic [31:0]     cache_data_i;
  logic [29:0]     cache_id_i;
  logic            cache_v_i;
  logic            cache_yumi_o;
  logic [31:0]     resp_data_o;
  logic [27:0]     resp_id_o;
  logic [N-1:0]    resp_v_o;
  logic [N-1:0]    resp_yumi_i;
  logic [N*CW-1:0] out_cnt_o;

  int total = 0;
  int bad   = 0;

  assign req_pkt_i = {pkt[3], pkt[2], pkt[1], pkt[0]};

  always #5 clk = ~clk;

  bsg_cache_non_blocking_req_arb #(
    .num_req_p(4), .id_width_p(30), .addr_width_p(32), .data_width_p(32),
    .block_size_in_words_p(8), .max_out_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_pkt_i(req_pkt_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
    .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o), .cache_ready_i(cache_ready_i),
    .cache_data_i(cache_data_i), .cache_id_i(cache_id_i), .cache_v_i(cache_v_i),
    .cache_yumi_o(cache_yumi_o),
    .resp_data_o(resp_data_o), .resp_id_o(resp_id_o), .resp_v_o(resp_v_o),
    .resp_yumi_i(resp_yumi_i), .out_cnt_o(out_cnt_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [5:0] op, input logic [27:0] id);
    return {op, 2'b00, id, {4'hA, id}, {4'hD, id}, 4'hF};
  endfunction

  function automatic logic [PW-1:0] stamp(input logic [PW-1:0] p, input logic [1:0] s);
    logic [PW-1:0] r;
    r = p;
    r[97:96] = s;
    return r;
  endfunction

  function automatic logic [CW-1:0] cnt(input int i);
    return out_cnt_o[i*CW +: CW];
  endfunction

  function automatic logic [1:0] gnt();
    return cache_pkt_o[97:96];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input int r, input int n);
    pkt[r] = mk_pkt(OP_LD, 28'h300 + 28'(r));
    req_v_i = 4'b0001 << r;
    cache_ready_i = 1'b1;
    repeat (n) tick();
    req_v_i = '0;
  endtask

  task automatic drain(input int s, input int n);
    for (int unsigned j = 0; j < n; j++) begin
      cache_v_i = 1'b1;
      cache_id_i = {2'(s), 28'h0};
      resp_yumi_i = '1;
      tick();
    end
    cache_v_i = 1'b0;
    resp_yumi_i = '0;
  endtask

  initial begin
    int acc;
    reset_i = 1'b1;
    req_v_i = '0;
    cache_ready_i = 1'b1;
    cache_data_i = '0;
    cache_id_i = '0;
    cache_v_i = 1'b0;
    resp_yumi_i = '0;
    for (int unsigned i = 0; i < N; i++) pkt[i] = mk_pkt(OP_LD, 28'h100 + 28'(i));

    // Reset state
    repeat (2) tick();
    settle();
    check("rst_cache_v", cache_v_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_resp_v", resp_v_o, 0);
    check("rst_cnt", out_cnt_o, 0);
    reset_i = 1'b0;
    tick();

    // Round-robin with all requesters busy; each accept answered next cycle
    for (int unsigned k = 0; k < 9; k++) begin
      req_v_i = (k < 8) ? 4'hF : 4'h0;
      if (k >= 1) begin
        cache_v_i = 1'b1;
        cache_id_i = {2'((k - 1) % 4), 28'(k)};
        resp_yumi_i = '1;
      end
      settle();
      if (k < 8) begin
        check("rr_grant", gnt(), 2'(k % 4));
        check("rr_ready", req_ready_o, 4'b0001 << (k % 4));
        check("rr_pkt", cache_pkt_o, stamp(pkt[k % 4], 2'(k % 4)));
      end
      if (k >= 1) begin
        check("rr_resp_v", resp_v_o, 4'b0001 << ((k - 1) % 4));
        check("rr_yumi", cache_yumi_o, 1);
      end
      tick();
    end
    cache_v_i = 1'b0;
    resp_yumi_i = '0;
    check("rr_cnt_zero", out_cnt_o, 0);

    // Credit limit on requester 1
    pkt[1] = mk_pkt(OP_LD, 28'h111);
    req_v_i = 4'b0010;
    acc = 0;
    for (int unsigned k = 0; k < 17; k++) begin
      settle();
      if (req_ready_o[1]) acc++;
      tick();
    end
    check("credit_accepts", acc, 16);
    check("credit_cnt1_full", cnt(1), 16);
    settle();
    check("credit_blocked_v", cache_v_o, 0);
    check("credit_blocked_rdy", req_ready_o, 0);
    pkt[2] = mk_pkt(OP_LD, 28'h222);
    req_v_i = 4'b0110;
    settle();
    check("credit_other_grant", gnt(), 2);
    check("credit_other_rdy", req_ready_o, 4'b0100);
    tick();
    req_v_i = 4'b0010;
    cache_v_i = 1'b1;
    cache_id_i = {2'd1, 28'h5};
    resp_yumi_i = 4'b0010;
    settle();
    check("credit_drain_yumi", cache_yumi_o, 1);
    check("credit_still_blocked", req_ready_o, 0);
    tick();
    cache_v_i = 1'b0;
    resp_yumi_i = '0;
    check("credit_cnt1_15", cnt(1), 15);
    settle();
    check("credit_17th_rdy", req_ready_o, 4'b0010);
    tick();
    check("credit_cnt1_refill", cnt(1), 16);
    req_v_i = '0;
    drain(1, 16);
    drain(2, 1);
    check("credit_cnt_zero", out_cnt_o, 0);

    // BLOCK_LD charge on requester 0
    issue(0, 9);
    check("blk_cnt0_9", cnt(0), 9);
    pkt[0] = mk_pkt(OP_BLK, 28'h200);
    req_v_i = 4'b0001;
    settle();
    check("blk_blocked_v", cache_v_o, 0);
    check("blk_blocked_rdy", req_ready_o, 0);
    pkt[3] = mk_pkt(OP_LD, 28'h333);
    req_v_i = 4'b1001;
    settle();
    check("blk_other_grant", gnt(), 3);
    check("blk_other_rdy", req_ready_o, 4'b1000);
    tick();
    req_v_i = 4'b0001;
    cache_v_i = 1'b1;
    cache_id_i = {2'd0, 28'h7};
    resp_yumi_i = 4'b0001;
    settle();
    check("blk_registered_cnt", req_ready_o, 0);
    tick();
    cache_v_i = 1'b0;
    resp_yumi_i = '0;
    check("blk_cnt0_8", cnt(0), 8);
    settle();
    check("blk_accept_rdy", req_ready_o, 4'b0001);
    check("blk_pkt", cache_pkt_o, stamp(pkt[0], 2'd0));
    tick();
    check("blk_cnt0_16", cnt(0), 16);
    req_v_i = '0;
    drain(0, 16);
    drain(3, 1);

    // Simultaneous charge and refund on requester 3
    issue(3, 5);
    check("incdec_pre", cnt(3), 5);
    pkt[3] = mk_pkt(OP_LD, 28'h333);
    req_v_i = 4'b1000;
    cache_v_i = 1'b1;
    cache_id_i = {2'd3, 28'h9};
    resp_yumi_i = 4'b1000;
    settle();
    check("incdec_rdy", req_ready_o, 4'b1000);
    check("incdec_yumi", cache_yumi_o, 1);
    tick();
    req_v_i = '0;
    cache_v_i = 1'b0;
    resp_yumi_i = '0;
    check("incdec_cnt3", cnt(3), 5);
    drain(3, 5);

    // Response steering with backpressure from requester 2
    issue(2, 1);
    cache_v_i = 1'b1;
    cache_id_i = {2'd2, 28'hABCDEF1};
    cache_data_i = 32'hCAFE_F00D;
    resp_yumi_i = 4'b1011;
    for (int unsigned c = 0; c < 4; c++) begin
      if (c == 3) resp_yumi_i = 4'b1111;
      settle();
      check("steer_resp_v", resp_v_o, 4'b0100);
      check("steer_yumi", cache_yumi_o, (c == 3) ? 1 : 0);
      check("steer_resp_id", resp_id_o, 28'hABCDEF1);
      if (c == 0) check("steer_data", resp_data_o, 32'hCAFE_F00D);
      if (c < 3) check("steer_cnt_hold", cnt(2), 1);
      tick();
    end
    cache_v_i = 1'b0;
    resp_yumi_i = '0;
    check("steer_cnt_done", cnt(2), 0);

    // Ready stall (pointer sits at 3, so 0 wins over 2), then reset
    pkt[0] = mk_pkt(OP_LD, 28'h100);
    pkt[2] = mk_pkt(OP_LD, 28'h102);
    req_v_i = 4'b0101;
    cache_ready_i = 1'b0;
    for (int unsigned c = 0; c < 5; c++) begin
      settle();
      check("stall_v", cache_v_o, 1);
      check("stall_rdy", req_ready_o, 0);
      check("stall_grant", gnt(), 0);
      tick();
    end
    cache_ready_i = 1'b1;
    settle();
    check("stall_release_rdy", req_ready_o, 4'b0001);
    tick();
    check("stall_cnt0", cnt(0), 1);
    settle();
    check("stall_ptr_moved", gnt(), 2);
    req_v_i = '0;
    reset_i = 1'b1;
    repeat (2) tick();
    settle();
    check("reset_cnt", out_cnt_o, 0);
    check("reset_cache_v", cache_v_o, 0);
    check("reset_rdy", req_ready_o, 0);
    reset_i = 1'b0;
    tick();
    req_v_i = 4'hF;
    settle();
    check("reset_ptr_grant", gnt(), 0);
    check("reset_ptr_rdy", req_ready_o, 4'b0001);
    tick();
    req_v_i = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
